// File: rtl/crypt_batch_sequencer.sv
// Batch encryption sequencer: runs N back-to-back AES encryptions with the iteration
// index inserted into key/text, tracking the last ciphertext and an XOR of all ciphertexts.
module crypt_batch_sequencer #(
    parameter int unsigned pIDX_BITS   = 8,
    parameter int unsigned pTIMEOUT    = 1024,
    parameter int unsigned pDATA_WIDTH = 128
) (
    input  logic                   usb_clk,
    input  logic                   reset_n,
    input  logic [pDATA_WIDTH-1:0] cfg_key,
    input  logic [pDATA_WIDTH-1:0] cfg_text,
    input  logic [pIDX_BITS:0]     cfg_count,
    input  logic                   batch_go,
    input  logic                   batch_abort,
    output logic [pDATA_WIDTH-1:0] core_key,
    output logic [pDATA_WIDTH-1:0] core_text,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [pDATA_WIDTH-1:0] core_cipher,
    output logic                   batch_busy,
    output logic                   batch_done,
    output logic [pIDX_BITS:0]     iter_cnt,
    output logic [pDATA_WIDTH-1:0] last_cipher,
    output logic [pDATA_WIDTH-1:0] cipher_xor,
    output logic                   err_timeout
);

    localparam int unsigned DW  = pDATA_WIDTH;
    localparam int unsigned IW  = pIDX_BITS;
    localparam int unsigned CW  = pIDX_BITS + 1;
    localparam int unsigned WDW = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;

    // Watchdog value whose increment reaches pTIMEOUT-1
    localparam logic [WDW-1:0] WD_LAST  = WDW'(pTIMEOUT - 2);
    localparam logic [DW-1:0]  IDX_MASK = {{(DW-IW){1'b0}}, {IW{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   key_q, text_q;
    logic [CW-1:0]   count_q;
    logic [IW-1:0]   idx_q;
    logic [WDW-1:0]  wd_q;
    logic [CW-1:0]   iter_inc;
    logic            accept, load, capture, expire, aborting;

    assign iter_inc = iter_cnt + CW'(1);
    assign aborting = batch_abort && (state != S_IDLE);

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (batch_go) begin
                    accept     = 1'b1;
                    state_next = (cfg_count == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                load       = 1'b1;
                state_next = S_START;
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    capture    = 1'b1;
                    state_next = (iter_inc == count_q) ? S_FINISH : S_LOAD;
                end else if (wd_q == WD_LAST) begin
                    expire     = 1'b1;
                    state_next = S_FINISH;
                end
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (aborting) begin
            state_next = S_IDLE;
            load       = 1'b0;
            capture    = 1'b0;
            expire     = 1'b0;
        end
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            key_q       <= '0;
            text_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            core_key    <= '0;
            core_text   <= '0;
            core_start  <= 1'b0;
            batch_busy  <= 1'b0;
            batch_done  <= 1'b0;
            iter_cnt    <= '0;
            last_cipher <= '0;
            cipher_xor  <= '0;
            err_timeout <= 1'b0;
        end else begin
            state      <= state_next;
            batch_busy <= (state_next != S_IDLE);
            core_start <= (state == S_START) && !aborting;
            batch_done <= (state == S_FINISH) && !aborting;

            if (accept) begin
                key_q       <= cfg_key;
                text_q      <= cfg_text;
                count_q     <= cfg_count;
                idx_q       <= '0;
                iter_cnt    <= '0;
                cipher_xor  <= '0;
                err_timeout <= 1'b0;
            end

            if (load) begin
                core_key  <= (key_q  & ~IDX_MASK) | DW'(idx_q);
                core_text <= (text_q & ~IDX_MASK) | DW'(idx_q);
            end

            if (state == S_START) begin
                wd_q <= '0;
            end else if (state == S_WAIT) begin
                wd_q <= wd_q + WDW'(1);
            end

            if (capture) begin
                last_cipher <= core_cipher;
                cipher_xor  <= cipher_xor ^ core_cipher;
                iter_cnt    <= iter_inc;
                idx_q       <= idx_q + IW'(1);
            end

            if (expire) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crypt_batch_sequencer.sv
// Bench for crypt_batch_sequencer: behavioural AES-core stand-in plus batch-level
// expectations derived from the key/text/index rules.
module tb_crypt_batch_sequencer;

    localparam int unsigned IW  = 8;
    localparam int unsigned CW  = IW + 1;
    localparam int unsigned DW  = 128;
    localparam int unsigned TMO = 16;
    localparam logic [DW-1:0] IDX_MASK = DW'(255);

    logic          usb_clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] cfg_key = '0;
    logic [DW-1:0] cfg_text = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          batch_go = 1'b0;
    logic          batch_abort = 1'b0;
    logic [DW-1:0] core_key, core_text;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_cipher = '0;
    logic          batch_busy, batch_done;
    logic [CW-1:0] iter_cnt;
    logic [DW-1:0] last_cipher, cipher_xor;
    logic          err_timeout;

    crypt_batch_sequencer #(
        .pIDX_BITS  (IW),
        .pTIMEOUT   (TMO),
        .pDATA_WIDTH(DW)
    ) dut (
        .usb_clk    (usb_clk),
        .reset_n    (reset_n),
        .cfg_key    (cfg_key),
        .cfg_text   (cfg_text),
        .cfg_count  (cfg_count),
        .batch_go   (batch_go),
        .batch_abort(batch_abort),
        .core_key   (core_key),
        .core_text  (core_text),
        .core_start (core_start),
        .core_done  (core_done),
        .core_cipher(core_cipher),
        .batch_busy (batch_busy),
        .batch_done (batch_done),
        .iter_cnt   (iter_cnt),
        .last_cipher(last_cipher),
        .cipher_xor (cipher_xor),
        .err_timeout(err_timeout)
    );

    initial forever #5 usb_clk = ~usb_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    initial forever begin
        @(posedge usb_clk);
        cyc++;
    end

    // Observation of the core interface and batch handshake
    logic [DW-1:0] obs_key_q[$];
    logic [DW-1:0] obs_text_q[$];
    int start_cnt = 0, done_cnt = 0, busy_cnt = 0;
    int first_start_cyc = 0, done_cyc = 0, go_cyc = 0;
    initial forever begin
        @(negedge usb_clk);
        if (reset_n) begin
            if (core_start) begin
                if (start_cnt == 0) first_start_cyc = cyc;
                obs_key_q.push_back(core_key);
                obs_text_q.push_back(core_text);
                start_cnt++;
            end
            if (batch_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (batch_busy) busy_cnt++;
        end
    end

    // AES core stand-in: cipher = key ^ text (optionally salted), fixed latency
    int lat = 10;
    bit mute = 1'b0;
    bit salt = 1'b0;
    bit pending = 1'b0;
    int cd = 0;
    logic [DW-1:0] pk, pt;
    logic [DW-1:0] prod_q[$];
    initial forever begin
        @(negedge usb_clk);
        core_done = 1'b0;
        if (!reset_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                cd--;
                if (cd == 0) begin
                    core_done   = 1'b1;
                    core_cipher = pk ^ pt ^ (salt ? {$urandom, $urandom, $urandom, $urandom} : DW'(0));
                    prod_q.push_back(core_cipher);
                    pending = 1'b0;
                end
            end
            if (core_start && !mute) begin
                pending = 1'b1;
                cd = lat;
                pk = core_key;
                pt = core_text;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed=still running expected=finished");
        $fatal(1, "simulation bound expired");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] idx_sub(input logic [DW-1:0] base, input int i);
        return (base & ~IDX_MASK) | DW'(i % 256);
    endfunction

    task automatic clear_obs();
        obs_key_q.delete();
        obs_text_q.delete();
        prod_q.delete();
        start_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic go(input logic [DW-1:0] k, input logic [DW-1:0] t, input int n);
        @(negedge usb_clk);
        cfg_key   = k;
        cfg_text  = t;
        cfg_count = CW'(n);
        batch_go  = 1'b1;
        go_cyc    = cyc;
        @(negedge usb_clk);
        batch_go  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge usb_clk);
            n++;
        end
        checks++;
        assert (done_cnt != 0) else begin
            errors++;
            $error("FAIL %s: batch_done pulses observed=0 expected=1 within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_starts(input string tag, input int want, input int budget);
        int n = 0;
        while (start_cnt < want && n < budget) begin
            @(negedge usb_clk);
            n++;
        end
        checks++;
        assert (start_cnt >= want) else begin
            errors++;
            $error("FAIL %s: core_start pulses observed=%0d expected>=%0d", tag, start_cnt, want);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   DW'(batch_busy),  '0);
        chk({tag, "_start"},  DW'(core_start),  '0);
        chk({tag, "_done"},   DW'(batch_done),  '0);
        chk({tag, "_iter"},   DW'(iter_cnt),    '0);
        chk({tag, "_last"},   last_cipher,      '0);
        chk({tag, "_xor"},    cipher_xor,       '0);
        chk({tag, "_err"},    DW'(err_timeout), '0);
        chk({tag, "_key"},    core_key,         '0);
        chk({tag, "_text"},   core_text,        '0);
    endtask

    // Batch-level expectations for a normally completed batch of n encryptions
    task automatic check_batch(input string tag, input logic [DW-1:0] k, input logic [DW-1:0] t, input int n);
        logic [DW-1:0] ex = '0;
        chk({tag, "_starts"}, DW'(start_cnt), DW'(n));
        for (int i = 0; i < n && i < obs_key_q.size(); i++) begin
            chk($sformatf("%s_key%0d", tag, i),  obs_key_q[i],  idx_sub(k, i));
            chk($sformatf("%s_text%0d", tag, i), obs_text_q[i], idx_sub(t, i));
        end
        foreach (prod_q[i]) ex ^= prod_q[i];
        chk({tag, "_done_once"}, DW'(done_cnt), DW'(1));
        chk({tag, "_iter"}, DW'(iter_cnt), DW'(n));
        chk({tag, "_xor"}, cipher_xor, ex);
        if (prod_q.size() > 0) chk({tag, "_last"}, last_cipher, prod_q[prod_q.size()-1]);
        chk({tag, "_busy_after"}, DW'(batch_busy), '0);
        chk({tag, "_err"}, DW'(err_timeout), '0);
    endtask

    initial begin
        logic [DW-1:0] k, t;
        int n;
        bit hit;

        // Reset
        #2 reset_n = 1'b0;
        #1 check_zero("reset");
        @(negedge usb_clk);
        @(negedge usb_clk);
        reset_n = 1'b1;

        // Directed sweep of four
        lat = 10; salt = 1'b0;
        clear_obs();
        k = {{120{1'b1}}, 8'h00};
        t = {1'b1, 127'b0};
        go(k, t, 4);
        wait_done("dir4", 200);
        repeat (3) @(negedge usb_clk);
        check_batch("dir4", k, t, 4);
        chk("dir4_go_to_start", DW'(first_start_cyc - go_cyc), DW'(3));
        chk("dir4_last_const", last_cipher, {1'b0, {119{1'b1}}, 8'h00});
        chk("dir4_xor_const", cipher_xor, '0);

        // count = 0
        clear_obs();
        go({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
        wait_done("zero", 20);
        repeat (3) @(negedge usb_clk);
        chk("zero_done_lat", DW'(done_cyc - go_cyc), DW'(2));
        chk("zero_starts", DW'(start_cnt), '0);
        chk("zero_iter", DW'(iter_cnt), '0);
        chk("zero_busy_cycles", DW'(busy_cnt), DW'(1));
        chk("zero_last_kept", last_cipher, {1'b0, {119{1'b1}}, 8'h00});

        // Randomized batches with cfg churn after go
        salt = 1'b1;
        for (int b = 0; b < 5; b++) begin
            clear_obs();
            k = {$urandom, $urandom, $urandom, $urandom};
            t = {$urandom, $urandom, $urandom, $urandom};
            n = (b == 0) ? 1 : int'($urandom_range(2, 6));
            lat = int'($urandom_range(1, 12));
            go(k, t, n);
            cfg_key   = {$urandom, $urandom, $urandom, $urandom};
            cfg_text  = {$urandom, $urandom, $urandom, $urandom};
            cfg_count = CW'($urandom_range(1, 255));
            wait_done($sformatf("rnd%0d", b), n * 30 + 20);
            repeat (3) @(negedge usb_clk);
            check_batch($sformatf("rnd%0d", b), k, t, n);
        end

        // Watchdog expiry
        mute = 1'b1;
        clear_obs();
        go({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 3);
        wait_done("tmo", 100);
        repeat (3) @(negedge usb_clk);
        chk("tmo_start_to_done", DW'(done_cyc - first_start_cyc), DW'(TMO));
        chk("tmo_err", DW'(err_timeout), DW'(1));
        chk("tmo_iter", DW'(iter_cnt), '0);
        chk("tmo_starts", DW'(start_cnt), DW'(1));
        chk("tmo_done_once", DW'(done_cnt), DW'(1));
        mute = 1'b0;
        clear_obs();
        go({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 0);
        wait_done("tmo_clear", 20);
        chk("tmo_err_cleared", DW'(err_timeout), '0);

        // Abort colliding with core_done in the third WAIT; stray go mid-batch
        lat = 10;
        clear_obs();
        k = {$urandom, $urandom, $urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        go(k, t, 8);
        wait_starts("abort_first", 1, 20);
        @(negedge usb_clk);
        cfg_key = ~k; cfg_text = ~t; cfg_count = CW'(1);
        batch_go = 1'b1;
        @(negedge usb_clk);
        batch_go = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge usb_clk);
            #1;
            if (core_done && prod_q.size() == 3) begin
                batch_abort = 1'b1;
                hit = 1'b1;
            end
        end
        chk("abort_hit", DW'(hit), DW'(1));
        @(negedge usb_clk);
        batch_abort = 1'b0;
        chk("abort_busy_low", DW'(batch_busy), '0);
        repeat (30) @(negedge usb_clk);
        chk("abort_iter", DW'(iter_cnt), DW'(2));
        chk("abort_no_done", DW'(done_cnt), '0);
        chk("abort_starts", DW'(start_cnt), DW'(3));
        for (int i = 0; i < 3 && i < obs_key_q.size(); i++)
            chk($sformatf("abort_key%0d", i), obs_key_q[i], idx_sub(k, i));
        if (prod_q.size() >= 2) begin
            chk("abort_last", last_cipher, prod_q[1]);
            chk("abort_xor", cipher_xor, prod_q[0] ^ prod_q[1]);
        end

        // Abort in IDLE is a no-op; go and abort together start a batch
        clear_obs();
        @(negedge usb_clk);
        batch_abort = 1'b1;
        @(negedge usb_clk);
        batch_abort = 1'b0;
        chk("idle_abort_busy", DW'(batch_busy), '0);
        k = {$urandom, $urandom, $urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        cfg_key = k; cfg_text = t; cfg_count = CW'(1);
        batch_go = 1'b1; batch_abort = 1'b1;
        @(negedge usb_clk);
        batch_go = 1'b0; batch_abort = 1'b0;
        wait_done("goabort", 60);
        repeat (3) @(negedge usb_clk);
        check_batch("goabort", k, t, 1);

        // Full 256-entry sweep
        lat = 1;
        clear_obs();
        k = {$urandom, $urandom, $urandom, $urandom};
        t = {$urandom, $urandom, $urandom, $urandom};
        go(k, t, 256);
        wait_done("full", 256 * 8 + 50);
        repeat (3) @(negedge usb_clk);
        check_batch("full", k, t, 256);
        if (obs_key_q.size() > 0)
            chk("full_last_idx", obs_key_q[obs_key_q.size()-1] & IDX_MASK, DW'(8'hFF));

        // Reset in the middle of a batch
        lat = 10;
        clear_obs();
        go({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 5);
        wait_starts("midrst", 2, 60);
        @(negedge usb_clk);
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge usb_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge usb_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
